rns5_to_bin_mrc: RTL and testbench

- Reverse (residue-to-binary) converter for the 5-modulus RNS set {101, 103, 107, 109, 113}.
- Companion to the binary-to-residue x_*_mod_* reducers; rebuilds the 34-bit integer X from its five 7-bit residues.
- Sequential mixed-radix conversion (MRC): one modular step per cycle, then Horner accumulation.
- Valid/ready on both sides; sits at the output of the RNS datapath.

---
 rtl/rns5_pkg.sv | 68 ++++++
 rtl/rns5_to_bin_mrc_if.sv | 30 +++
 rtl/rns_mrc_step.sv | 40 ++++
 rtl/rns5_to_bin_mrc.sv | 114 +++++++++++
 tb/tb_rns5_to_bin_mrc.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rns5_pkg.sv
// Constants and helpers for the {101,103,107,109,113} residue-to-binary converter.
// INV_i_j is m_j^-1 mod m_i, used by the mixed-radix digit recurrence.
package rns5_pkg;

  localparam int XW = 34;
  localparam int RW = 7;

  localparam logic [RW-1:0] M1 = 7'd101;
  localparam logic [RW-1:0] M2 = 7'd103;
  localparam logic [RW-1:0] M3 = 7'd107;
  localparam logic [RW-1:0] M4 = 7'd109;
  localparam logic [RW-1:0] M5 = 7'd113;

  localparam logic [XW-1:0] MTOT = 34'd13710311357;
  localparam logic [XW-1:0] P1   = 34'd101;
  localparam logic [XW-1:0] P2   = 34'd10403;
  localparam logic [XW-1:0] P3   = 34'd1113121;
  localparam logic [XW-1:0] P4   = 34'd121330189;

  localparam logic [RW-1:0] INV_2_1 = 7'd51;
  localparam logic [RW-1:0] INV_3_1 = 7'd89;
  localparam logic [RW-1:0] INV_3_2 = 7'd80;
  localparam logic [RW-1:0] INV_4_1 = 7'd68;
  localparam logic [RW-1:0] INV_4_2 = 7'd18;
  localparam logic [RW-1:0] INV_4_3 = 7'd54;
  localparam logic [RW-1:0] INV_5_1 = 7'd47;
  localparam logic [RW-1:0] INV_5_2 = 7'd79;
  localparam logic [RW-1:0] INV_5_3 = 7'd94;
  localparam logic [RW-1:0] INV_5_4 = 7'd28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MRC  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [RW-1:0] mod_of(input logic [2:0] idx);
    logic [RW-1:0] m;
    case (idx)
      3'd2:    m = M2;
      3'd3:    m = M3;
      3'd4:    m = M4;
      3'd5:    m = M5;
      default: m = M1;
    endcase
    return m;
  endfunction

  function automatic logic [RW-1:0] inv_of(input logic [2:0] i, input logic [2:0] j);
    logic [RW-1:0] v;
    case ({i, j})
      6'o21:   v = INV_2_1;
      6'o31:   v = INV_3_1;
      6'o32:   v = INV_3_2;
      6'o41:   v = INV_4_1;
      6'o42:   v = INV_4_2;
      6'o43:   v = INV_4_3;
      6'o51:   v = INV_5_1;
      6'o52:   v = INV_5_2;
      6'o53:   v = INV_5_3;
      6'o54:   v = INV_5_4;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rns5_to_bin_mrc_if.sv
// Residue-in / integer-out bus of the converter. master = upstream/downstream
// environment, slave = converter.
interface rns5_to_bin_mrc_if;

  // A transfer happens on a rising clock edge where valid and ready are both 1;
  // a source holds valid and its payload stable until that edge, and ready may
  // depend on state only, never combinationally on valid.
  logic [rns5_pkg::RW-1:0] R1;
  logic [rns5_pkg::RW-1:0] R2;
  logic [rns5_pkg::RW-1:0] R3;
  logic [rns5_pkg::RW-1:0] R4;
  logic [rns5_pkg::RW-1:0] R5;
  logic                    in_valid;
  logic                    in_ready;
  logic [rns5_pkg::XW-1:0] X;
  logic                    err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output R1, R2, R3, R4, R5, in_valid, out_ready,
    input  in_ready, X, err, out_valid
  );

  modport slave (
    input  R1, R2, R3, R4, R5, in_valid, out_ready,
    output in_ready, X, err, out_valid
  );

endinterface

// File: rtl/rns_mrc_step.sv
// One mixed-radix step: ((t - a) mod m) * inv mod m, with the 14-bit product
// reduced by repeated 2^7 == (128 - m) folding and a final conditional subtract.
module rns_mrc_step
  import rns5_pkg::*;
(
  input  logic [RW-1:0] i_t,
  input  logic [RW-1:0] i_a,
  input  logic [RW-1:0] i_inv,
  input  logic [2:0]    i_sel,
  output logic [RW-1:0] o_r
);

  logic [RW-1:0] w_m;
  logic [RW-1:0] w_c;
  logic [7:0]    w_d;
  logic [RW-1:0] w_diff;
  logic [13:0]   w_p;
  logic [12:0]   w_s1;
  logic [10:0]   w_s2;
  logic [9:0]    w_s3;
  logic [8:0]    w_s4;
  logic [8:0]    w_r1;

  assign w_m = mod_of(i_sel);
  assign w_c = 7'd0 - w_m;

  // a < m_j < m_i, so one correction brings the difference into [0, m_i).
  assign w_d    = {1'b0, i_t} - {1'b0, i_a};
  assign w_diff = w_d[7] ? 7'(w_d + {1'b0, w_m}) : w_d[6:0];

  assign w_p  = {7'd0, w_diff} * {7'd0, i_inv};
  assign w_s1 = 13'(w_p[13:7])  * 13'(w_c) + 13'(w_p[6:0]);
  assign w_s2 = 11'(w_s1[12:7]) * 11'(w_c) + 11'(w_s1[6:0]);
  assign w_s3 = 10'(w_s2[10:7]) * 10'(w_c) + 10'(w_s2[6:0]);
  assign w_s4 = 9'(w_s3[9:7])   * 9'(w_c)  + 9'(w_s3[6:0]);

  assign w_r1 = (w_s4 >= 9'(w_m)) ? (w_s4 - 9'(w_m)) : w_s4;
  assign o_r  = (w_r1 >= 9'(w_m)) ? 7'(w_r1 - 9'(w_m)) : w_r1[6:0];

endmodule

// File: rtl/rns5_to_bin_mrc.sv
// Residue-to-binary converter: load, ten mixed-radix steps, four Horner
// multiply-adds, then hold the result until the downstream takes it.
module rns5_to_bin_mrc
  import rns5_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rns5_to_bin_mrc_if.slave     bus,
  output state_t               o_state
);

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_t [1:5];
  logic [2:0]    r_i;
  logic [2:0]    r_j;
  logic [1:0]    r_k;
  logic [XW-1:0] r_x;
  logic          r_err;

  logic          w_bad;
  logic          w_mrc_last;
  logic [RW-1:0] w_step;
  logic [2:0]    w_acc_idx;
  logic [XW-1:0] w_mac;

  assign w_bad = (bus.R1 >= M1) | (bus.R2 >= M2) | (bus.R3 >= M3) |
                 (bus.R4 >= M4) | (bus.R5 >= M5);

  assign w_mrc_last = (r_i == 3'd5) && (r_j == 3'd4);

  rns_mrc_step u_step (
    .i_t   (r_t[r_i]),
    .i_a   (r_t[r_j]),
    .i_inv (inv_of(r_i, r_j)),
    .i_sel (r_i),
    .o_r   (w_step)
  );

  // Horner step k multiplies by m_(4-k) and adds digit a_(4-k).
  assign w_acc_idx = 3'd4 - {1'b0, r_k};
  assign w_mac     = r_x * XW'(mod_of(w_acc_idx)) + XW'(r_t[w_acc_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = w_bad ? DONE : MRC;
      end
      MRC:  if (w_mrc_last) w_next = ACC;
      ACC:  if (r_k == 2'd3) w_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n <= 5; n++) r_t[n] <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_x   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_t[1] <= bus.R1;
          r_t[2] <= bus.R2;
          r_t[3] <= bus.R3;
          r_t[4] <= bus.R4;
          r_t[5] <= bus.R5;
          r_i    <= 3'd2;
          r_j    <= 3'd1;
          r_k    <= 2'd0;
          r_x    <= '0;
          r_err  <= w_bad;
        end
        MRC: begin
          r_t[r_i] <= w_step;
          if (r_j == r_i - 3'd1) begin
            // a5 seeds the Horner accumulator.
            if (r_i == 3'd5) r_x <= XW'(w_step);
            else             r_i <= r_i + 3'd1;
            r_j <= 3'd1;
          end else begin
            r_j <= r_j + 3'd1;
          end
        end
        ACC: begin
          r_x <= w_mac;
          r_k <= r_k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.X   = r_x;
  assign bus.err = r_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_rns5_to_bin_mrc.sv
// Directed bench for rns5_to_bin_mrc: known residue vectors, illegal input,
// backpressure, mid-conversion reset and a short seeded sweep.
module tb_rns5_to_bin_mrc;
  import rns5_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks;
  int     n_errors;
  logic [XW-1:0] exp_q[$];

  rns5_to_bin_mrc_if bus ();

  rns5_to_bin_mrc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [6:0] r1, r2, r3, r4, r5);
    int n;
    n = 0;
    @(negedge clk);
    bus.R1 = r1; bus.R2 = r2; bus.R3 = r3; bus.R4 = r4; bus.R5 = r5;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) to the first out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 60);
    chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [6:0] r1, r2, r3, r4, r5,
                         input logic [63:0] ex, input logic ee, input int el);
    int lat;
    logic [XW-1:0] want;
    send(r1, r2, r3, r4, r5);
    exp_q.push_back(XW'(ex));
    wait_out(lat);
    want = exp_q.pop_front();
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_x"},   64'(bus.X), 64'(want));
    chk({tag, "_err"}, 64'(bus.err), 64'(ee));
    take();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] xr;
    logic [XW-1:0] x_hold;
    int lat;
    int seen;
    logic [6:0] mi, mj;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.R1 = '0; bus.R2 = '0; bus.R3 = '0; bus.R4 = '0; bus.R5 = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Offline inverse table: m_j * INV[i][j] mod m_i must be 1.
    for (int i = 2; i <= 5; i++) begin
      for (int j = 1; j < i; j++) begin
        mi = mod_of(3'(i));
        mj = mod_of(3'(j));
        chk($sformatf("inv_%0d_%0d", i, j),
            64'((32'(mj) * 32'(inv_of(3'(i), 3'(j)))) % 32'(mi)), 64'd1);
      end
    end
    chk("mtot", 64'(MTOT), 64'(P4) * 64'd113);

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_x",         64'(bus.X), 64'd0);
    chk("rst_err",       64'(bus.err), 64'd0);
    chk("rst_state",     64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;

    // out_ready with nothing pending must not disturb anything.
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_oready_ov", 64'(bus.out_valid), 64'd0);
    chk("idle_oready_ir", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;

    convert("zero",  7'd0,   7'd0,   7'd0,   7'd0,   7'd0,   64'd0,     1'b0, 15);
    convert("one",   7'd1,   7'd1,   7'd1,   7'd1,   7'd1,   64'd1,     1'b0, 15);
    convert("k12345",7'd23,  7'd88,  7'd40,  7'd28,  7'd28,  64'd12345, 1'b0, 15);
    convert("k107",  7'd6,   7'd4,   7'd0,   7'd107, 7'd107, 64'd107,   1'b0, 15);
    convert("max",   7'd100, 7'd102, 7'd106, 7'd108, 7'd112, 64'd13710311356, 1'b0, 15);
    convert("bad_r3",7'd0,   7'd0,   7'd107, 7'd0,   7'd0,   64'd0,     1'b1, 1);
    convert("bad_r1",7'd127, 7'd5,   7'd5,   7'd5,   7'd5,   64'd0,     1'b1, 1);
    convert("after_bad", 7'd23, 7'd88, 7'd40, 7'd28, 7'd28, 64'd12345, 1'b0, 15);

    // Backpressure: hold result 20 cycles while the next input waits.
    send(7'd23, 7'd88, 7'd40, 7'd28, 7'd28);
    wait_out(lat);
    chk("bp_lat", 64'(lat), 64'd15);
    x_hold = bus.X;
    chk("bp_x", 64'(x_hold), 64'd12345);
    bus.R1 = 7'd100; bus.R2 = 7'd102; bus.R3 = 7'd106; bus.R4 = 7'd108; bus.R5 = 7'd112;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_hold_x",  64'(bus.X), 64'(x_hold));
      chk("bp_hold_ir", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_ov", 64'(bus.out_valid), 64'd1);
    end
    take();
    @(negedge clk);
    chk("bp_next_ir", 64'(bus.in_ready), 64'd1);
    chk("bp_next_ov", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(lat);
    chk("bp2_lat", 64'(lat), 64'd15);
    chk("bp2_x",   64'(bus.X), 64'd13710311356);
    take();

    // Reset during the MRC phase discards the conversion.
    send(7'd23, 7'd88, 7'd40, 7'd28, 7'd28);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ir",    64'(bus.in_ready), 64'd1);
    chk("mid_rst_ov",    64'(bus.out_valid), 64'd0);
    chk("mid_rst_x",     64'(bus.X), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_out", 64'(seen), 64'd0);
    chk("mid_rst_ir_after", 64'(bus.in_ready), 64'd1);
    convert("post_rst", 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 64'd1, 1'b0, 15);

    // Seeded sweep with idle gaps on both sides.
    for (int k = 0; k < 40; k++) begin
      xr = {$urandom(), $urandom()} % 64'(MTOT);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(7'(xr % 64'd101), 7'(xr % 64'd103), 7'(xr % 64'd107),
           7'(xr % 64'd109), 7'(xr % 64'd113));
      exp_q.push_back(XW'(xr));
      wait_out(lat);
      chk("rnd_lat", 64'(lat), 64'd15);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rnd_x",   64'(bus.X), 64'(exp_q.pop_front()));
      chk("rnd_err", 64'(bus.err), 64'd0);
      take();
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
